// File: rtl/req_pending_4_pkg.sv
// rtl/req_pending_4_pkg.sv - shared constants for the request-capture stage
package req_pending_4_pkg;
   localparam int N_REQ = 4;
   localparam int IDX_W = 2;
   localparam logic [3:0] MASK_RST = 4'b0000;
endpackage

// File: rtl/req_pending_4_sync2.sv
// rtl/req_pending_4_sync2.sv - 1-bit two-flop synchroniser
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic s1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end
endmodule

// File: rtl/req_pending_4.sv
// rtl/req_pending_4.sv - request capture: sync, edge detect, sticky pending, mask
module req_pending_4
   import req_pending_4_pkg::*;
#(
   parameter int N_REQ = req_pending_4_pkg::N_REQ,
   parameter int IDX_W = req_pending_4_pkg::IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_in,
   input  logic             mask_we,
   input  logic [N_REQ-1:0] mask_in,
   input  logic             ack,
   input  logic [IDX_W-1:0] ack_idx,
   input  logic             ovf_clr,
   output logic [N_REQ-1:0] pend,
   output logic             pend_any,
   output logic [N_REQ-1:0] ovf
);
   logic [N_REQ-1:0] s2;
   logic [N_REQ-1:0] s3;
   logic [N_REQ-1:0] evt;
   logic [N_REQ-1:0] ack_hit;
   logic [N_REQ-1:0] ovf_set;
   logic [N_REQ-1:0] praw;
   logic [N_REQ-1:0] praw_nxt;
   logic [N_REQ-1:0] mask_q;
   logic [N_REQ-1:0] ovf_q;
   logic [N_REQ-1:0] pend_q;
   logic             pend_any_q;

   for (genvar g = 0; g < N_REQ; g++) begin : g_sync
      sync2 u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (req_in[g]),
         .q     (s2[g])
      );
   end

   assign evt = s2 & ~s3;

   always_comb begin
      ack_hit = '0;
      for (int k = 0; k < N_REQ; k++) begin
         ack_hit[k] = ack && (ack_idx == IDX_W'(k));
      end
   end

   // A coincident ack services the old event, so the new one is not an overflow.
   assign ovf_set  = evt & praw & ~ack_hit;
   assign praw_nxt = evt | (praw & ~ack_hit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3         <= '0;
         praw       <= '0;
         ovf_q      <= '0;
         mask_q     <= MASK_RST;
         pend_q     <= '0;
         pend_any_q <= 1'b0;
      end else begin
         s3         <= s2;
         praw       <= praw_nxt;
         ovf_q      <= (ovf_clr ? '0 : ovf_q) | ovf_set;
         if (mask_we) begin
            mask_q <= mask_in;
         end
         pend_q     <= praw & ~mask_q;
         pend_any_q <= |(praw & ~mask_q);
      end
   end

   assign pend     = pend_q;
   assign pend_any = pend_any_q;
   assign ovf      = ovf_q;
endmodule

// File: tb/tb_req_pending_4.sv
// tb/tb_req_pending_4.sv - scoreboard bench with behavioural model for req_pending_4
module tb_req_pending_4;
   logic       clk;
   logic       rst_n;
   logic [3:0] req_in;
   logic       mask_we;
   logic [3:0] mask_in;
   logic       ack;
   logic [1:0] ack_idx;
   logic       ovf_clr;
   logic [3:0] pend;
   logic       pend_any;
   logic [3:0] ovf;

   req_pending_4 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_in   (req_in),
      .mask_we  (mask_we),
      .mask_in  (mask_in),
      .ack      (ack),
      .ack_idx  (ack_idx),
      .ovf_clr  (ovf_clr),
      .pend     (pend),
      .pend_any (pend_any),
      .ovf      (ovf)
   );

   typedef struct packed {
      logic [3:0] pend;
      logic       any;
      logic [3:0] ovf;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   bit   started = 0;
   bit   done = 0;

   // model state: what has been captured, what the consumer sees, what overflowed
   logic [3:0] m_captured, m_visible, m_ovf, m_mask;
   logic       m_any;
   logic [3:0] seen[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int top_bit(input logic [3:0] v);
      int r = -1;
      for (int k = 0; k < 4; k++) if (v[k]) r = k;
      return r;
   endfunction

   // One clock: a rising edge becomes visible as an event two samples after it is first seen.
   task automatic tick();
      logic [3:0] rise;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_captured = 0; m_visible = 0; m_any = 0; m_ovf = 0; m_mask = 0;
         seen = '{4'h0, 4'h0, 4'h0};
      end else begin
         rise = seen[1] & ~seen[2];
         m_visible = m_captured & ~m_mask;
         m_any = (m_visible != 0);
         if (ovf_clr) m_ovf = 0;
         for (int k = 0; k < 4; k++) begin
            if (rise[k]) begin
               if (m_captured[k] && !(ack && ack_idx == k)) m_ovf[k] = 1'b1;
               m_captured[k] = 1'b1;
            end else if (ack && ack_idx == k) begin
               m_captured[k] = 1'b0;
            end
         end
         if (mask_we) m_mask = mask_in;
         seen.push_front(req_in);
         void'(seen.pop_back());
      end
      sb.push_back('{m_visible, m_any, m_ovf});
      started = 1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (started && !done) begin
         if (sb.size() == 0) begin
            chk("sb_empty", 8'd0, 8'd1);
         end else begin
            e = sb.pop_front();
            chk("pend", {4'h0, pend}, {4'h0, e.pend});
            chk("pend_any", {7'h0, pend_any}, {7'h0, e.any});
            chk("ovf", {4'h0, ovf}, {4'h0, e.ovf});
            chk("any_is_or", {7'h0, pend_any}, {7'h0, |pend});
         end
      end
   end

   task automatic pulse(input logic [3:0] v, input int hi, input int lo);
      req_in = v;
      repeat (hi) tick();
      req_in = 4'h0;
      repeat (lo) tick();
   endtask

   task automatic do_ack(input logic [1:0] idx);
      ack = 1'b1; ack_idx = idx;
      tick();
      ack = 1'b0;
      tick();
   endtask

   initial begin
      logic [3:0] rem;
      int exp_i, got_i;
      seen = '{4'h0, 4'h0, 4'h0};
      rst_n = 1'b0; req_in = 0; mask_we = 0; mask_in = 0; ack = 0; ack_idx = 0; ovf_clr = 0;
      m_captured = 0; m_visible = 0; m_any = 0; m_ovf = 0; m_mask = 0;
      #1;
      chk("reset_pend", {4'h0, pend}, 8'h00);
      chk("reset_ovf", {4'h0, ovf}, 8'h00);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // single event: visible exactly three edges after first sample
      req_in = 4'b0100;
      tick(); tick(); tick();
      chk("single_early", {4'h0, pend}, 8'h00);
      req_in = 4'b0000;
      tick();
      chk("single_pend", {4'h0, pend}, 8'h04);
      chk("single_any", {7'h0, pend_any}, 8'h01);
      chk("single_ovf", {4'h0, ovf}, 8'h00);
      do_ack(2'd2);

      // ack of a pending line, then a repeated ack
      pulse(4'b1010, 3, 4);
      chk("ack_pre", {4'h0, pend}, 8'h0a);
      do_ack(2'd3);
      chk("ack_one", {4'h0, pend}, 8'h02);
      do_ack(2'd3);
      chk("ack_again", {4'h0, pend}, 8'h02);

      // second edge on a pending line overflows
      pulse(4'b0001, 3, 3);
      pulse(4'b0001, 3, 4);
      chk("ovf_line0", {4'h0, ovf}, 8'h01);

      // edge on line 1 in the same cycle as its ack
      req_in = 4'b0010;
      tick(); tick();
      ack = 1'b1; ack_idx = 2'd1;
      tick();
      ack = 1'b0;
      tick(); tick();
      req_in = 4'b0000;
      tick();
      chk("simul_pend1", {7'h0, pend[1]}, 8'h01);
      chk("simul_ovf1", {7'h0, ovf[1]}, 8'h00);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      tick();
      chk("ovf_clr", {4'h0, ovf}, 8'h00);
      do_ack(2'd0);
      do_ack(2'd1);

      // masked line records but stays hidden until unmasked
      mask_we = 1'b1; mask_in = 4'b1000;
      tick();
      mask_we = 1'b0;
      pulse(4'b1000, 3, 3);
      chk("mask_pend", {4'h0, pend}, 8'h00);
      chk("mask_any", {7'h0, pend_any}, 8'h00);
      mask_we = 1'b1; mask_in = 4'b0000;
      tick();
      mask_we = 1'b0;
      tick();
      chk("unmask_pend", {4'h0, pend}, 8'h08);
      do_ack(2'd3);

      // asynchronous reset mid-operation
      pulse(4'b1111, 3, 3);
      pulse(4'b0011, 3, 4);
      chk("pre_rst_pend", {4'h0, pend}, 8'h0f);
      chk("pre_rst_ovf", {4'h0, ovf}, 8'h03);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_pend", {4'h0, pend}, 8'h00);
      chk("async_any", {7'h0, pend_any}, 8'h00);
      chk("async_ovf", {4'h0, ovf}, 8'h00);
      sb.delete();
      sb.push_back('0);
      req_in = 4'b0001;
      tick(); tick();
      rst_n = 1'b1;
      repeat (6) tick();
      chk("post_rst_pend", {4'h0, pend}, 8'h01);
      do_ack(2'd0);
      tick(); tick(); tick();
      chk("held_one_event", {4'h0, pend}, 8'h00);
      req_in = 4'b0000;
      tick(); tick(); tick();

      // encoder-style sweep: service highest index first
      for (int p = 0; p < 16; p++) begin
         pulse(4'(p), 3, 3);
         rem = 4'(p);
         chk("sweep_any", {7'h0, pend_any}, {7'h0, (rem != 0)});
         for (int i = 0; i < 4; i++) begin
            if (rem != 0) begin
               exp_i = top_bit(rem);
               got_i = top_bit(pend);
               chk("sweep_order", 8'(got_i), 8'(exp_i));
               do_ack(2'(exp_i));
               rem[exp_i] = 1'b0;
            end
         end
         chk("sweep_clear", {4'h0, pend}, 8'h00);
      end

      // randomized traffic
      for (int c = 0; c < 800; c++) begin
         if (c % 3 == 0) req_in = 4'($urandom);
         ack     = ($urandom_range(0, 2) == 0);
         ack_idx = 2'($urandom);
         mask_we = ($urandom_range(0, 19) == 0);
         mask_in = 4'($urandom);
         ovf_clr = ($urandom_range(0, 14) == 0);
         tick();
      end
      req_in = 0; ack = 0; mask_we = 0; ovf_clr = 0;
      tick(); tick();
      @(negedge clk);
      #1;
      done = 1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
